stopwatch_bcd_core: RTL



---
 rtl/stopwatch_bcd_core.sv | 106 ++++++++++
 1 files changed

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core: BCD 00.00-99.99 up/down stopwatch core; optional lap hold under STOPWATCH_LAP_EN
module stopwatch_bcd_core #(
  parameter int TICK_DIV = 1_000_000,
  parameter int TW = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       m,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [2:0] state
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RUN = 3'd1;
  localparam logic [2:0] PAUSE = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  logic [2:0] r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [15:0] r_cnt, w_cnt_nxt, w_step, w_disp;
  logic r_start_q, r_mode, w_sedge, w_tick, w_term;
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic dn);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (dn) begin
          c = r[4*i+:4] == 4'd0;
          r[4*i+:4] = c ? 4'd9 : r[4*i+:4] - 4'd1;
        end else begin
          c = r[4*i+:4] == 4'd9;
          r[4*i+:4] = c ? 4'd0 : r[4*i+:4] + 4'd1;
        end
      end
    end
    return r;
  endfunction
  assign w_sedge = start & ~r_start_q;
  assign w_tick = (r_state == RUN) && (r_tick == TW'(TICK_DIV - 1));
  assign w_step = bcd_step(r_cnt, r_mode);
  assign w_term = w_tick && (w_step == (r_mode ? 16'h0000 : 16'h9999));
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_state_nxt;
  // next state; a terminal tick overrides a simultaneous start edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_sedge ? RUN : IDLE;
      RUN:     w_state_nxt = w_term ? DONE : (w_sedge ? PAUSE : RUN);
      PAUSE:   w_state_nxt = w_sedge ? RUN : PAUSE;
      default: w_state_nxt = w_sedge ? IDLE : r_state;
    endcase
  end
  // datapath next values: reload in IDLE, step on tick in RUN, hold otherwise
  always_comb begin
    w_cnt_nxt = (r_state == IDLE) ? (m ? 16'h9999 : 16'h0000) : (w_tick ? w_step : r_cnt);
    w_tick_nxt = (r_state == IDLE) ? '0 : (r_state == RUN) ? (w_tick ? '0 : r_tick + TW'(1)) : r_tick;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_tick <= '0;
      r_start_q <= 1'b0;
      r_mode <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tick <= w_tick_nxt;
      r_start_q <= start;
      r_mode <= (r_state == IDLE && w_sedge) ? m : r_mode;
    end
  end
`ifdef STOPWATCH_LAP_EN
  logic r_lap_q, r_hold, w_hold_nxt;
  logic [15:0] r_disp;
  // lap edge in RUN toggles the hold; leaving for IDLE or DONE always releases it
  always_comb
    w_hold_nxt = (w_state_nxt == IDLE || w_state_nxt == DONE) ? 1'b0 :
                 (r_state == RUN && lap && !r_lap_q) ? !r_hold : r_hold;
  // display register doubles as the snapshot while the hold stays set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lap_q <= 1'b0;
      r_hold <= 1'b0;
      r_disp <= '0;
    end else begin
      r_lap_q <= lap;
      r_hold <= w_hold_nxt;
      r_disp <= (w_hold_nxt && r_hold) ? r_disp : w_cnt_nxt;
    end
  end
  assign w_disp = r_disp;
`else
  assign w_disp = r_cnt;
`endif
  assign {d3, d2, d1, d0} = w_disp;
  assign state = r_state;
endmodule
